// File: rtl/alu_exec_unit.sv
// Execution unit: registered single-cycle ALU operations plus an iterative
// signed shift-add multiplier, with valid/ready handshakes on both sides.
module alu_exec_unit #(
    parameter int DATA_W    = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [3:0]        ctrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic [DATA_W-1:0] hi_o,
    output logic              zero_o,
    output logic              illegal_o
);
    localparam int SHAMT_W = $clog2(DATA_W);
    localparam int CNT_W   = $clog2(MUL_STEPS);

    localparam logic [3:0] OP_BLEZ = 4'd7;
    localparam logic [3:0] OP_SMUL = 4'd13;
    localparam logic [3:0] OP_BGTZ = 4'd14;
    localparam logic [3:0] OP_ILL  = 4'd15;

    localparam logic [DATA_W-1:0]   ONE_W = DATA_W'(1);
    localparam logic [2*DATA_W-1:0] ONE_P = (2*DATA_W)'(1);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t                    state, state_nxt;
    logic                      accept;
    logic                      mul_last;
    logic [CNT_W-1:0]          mul_cnt;
    logic [DATA_W-1:0]         mcand_p0;
    logic [DATA_W-1:0]         acc_hi_p0;
    logic [DATA_W-1:0]         acc_lo_p0;
    logic                      mul_neg_p0;
    logic [DATA_W:0]           step_sum;
    logic [DATA_W-1:0]         step_hi;
    logic [DATA_W-1:0]         step_lo;
    logic [2*DATA_W-1:0]       prod_mag;
    logic [2*DATA_W-1:0]       prod_signed;
    logic [DATA_W-1:0]         alu_res;
    logic                      alu_zero;

    // Magnitude as unsigned; the most negative value maps to 2^(DATA_W-1).
    function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] x);
        logic [DATA_W-1:0] u;
        u = x;
        return x[DATA_W-1] ? (~u + ONE_W) : u;
    endfunction

    function automatic logic [DATA_W-1:0] alu_op(input logic [3:0] ctrl,
                                                 input logic signed [DATA_W-1:0] a,
                                                 input logic signed [DATA_W-1:0] b);
        logic [SHAMT_W-1:0] sh;
        sh = a[SHAMT_W-1:0];
        case (ctrl)
            4'd0:             return a & b;
            4'd1:             return a | b;
            4'd2, 4'd3, 4'd4: return a + b;
            4'd5:             return a - b;
            4'd6:             return DATA_W'(a < b);
            4'd11:            return DATA_W'($unsigned(a) < $unsigned(b));
            4'd7, 4'd14:      return a;
            4'd8, 4'd9:       return b >>> sh;
            4'd12:            return b << sh;
            4'd10:            return b << 16;
            default:          return '0;
        endcase
    endfunction

    function automatic logic zero_flag(input logic [3:0] ctrl,
                                       input logic signed [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] res);
        case (ctrl)
            OP_BLEZ: return a <= 0;
            OP_BGTZ: return a > 0;
            OP_ILL:  return 1'b0;
            default: return res == '0;
        endcase
    endfunction

    assign ready_o  = (state == IDLE) || ((state == DONE) && ready_i);
    assign valid_o  = (state == DONE);
    assign accept   = valid_i && ready_o;
    assign mul_last = (state == MUL) && (mul_cnt == CNT_W'(MUL_STEPS - 1));

    always_comb begin
        alu_res  = alu_op(ctrl_i, src1_i, src2_i);
        alu_zero = zero_flag(ctrl_i, src1_i, alu_res);
    end

    // Shift-add step: add the multiplicand into the high word when the
    // multiplier LSB is set, then shift {carry, hi, lo} right by one.
    always_comb begin
        step_sum    = {1'b0, acc_hi_p0} + (acc_lo_p0[0] ? {1'b0, mcand_p0} : '0);
        step_hi     = step_sum[DATA_W:1];
        step_lo     = {step_sum[0], acc_lo_p0[DATA_W-1:1]};
        prod_mag    = {step_hi, step_lo};
        prod_signed = mul_neg_p0 ? (~prod_mag + ONE_P) : prod_mag;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (valid_i) state_nxt = (ctrl_i == OP_SMUL) ? MUL : DONE;
            MUL:  if (mul_last) state_nxt = DONE;
            DONE: begin
                if (ready_i) begin
                    if (!valid_i)                state_nxt = IDLE;
                    else if (ctrl_i == OP_SMUL)  state_nxt = MUL;
                    else                         state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            mul_cnt   <= '0;
            result_o  <= '0;
            hi_o      <= '0;
            zero_o    <= 1'b0;
            illegal_o <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mul_cnt <= '0;
                if (ctrl_i != OP_SMUL) begin
                    result_o  <= alu_res;
                    hi_o      <= '0;
                    zero_o    <= alu_zero;
                    illegal_o <= (ctrl_i == OP_ILL);
                end
            end else if (state == MUL) begin
                mul_cnt <= mul_cnt + CNT_W'(1);
                if (mul_last) begin
                    result_o  <= prod_signed[DATA_W-1:0];
                    hi_o      <= prod_signed[2*DATA_W-1:DATA_W];
                    zero_o    <= (prod_mag == '0);
                    illegal_o <= 1'b0;
                end
            end
        end
    end

    // Multiplier datapath: operand magnitudes latched on accept, then stepped.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mcand_p0   <= abs_val(src1_i);
            acc_lo_p0  <= abs_val(src2_i);
            acc_hi_p0  <= '0;
            mul_neg_p0 <= src1_i[DATA_W-1] ^ src2_i[DATA_W-1];
        end else if (state == MUL) begin
            acc_hi_p0 <= step_hi;
            acc_lo_p0 <= step_lo;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors push expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_alu_exec_unit;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  ctrl_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic [31:0] hi_o;
    logic        zero_o;
    logic        illegal_o;

    always #5 clk_i = ~clk_i;

    alu_exec_unit #(.DATA_W(32), .MUL_STEPS(32)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .ctrl_i   (ctrl_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .hi_o     (hi_o),
        .zero_o   (zero_o),
        .illegal_o(illegal_o)
    );

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        logic        ill;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_i === 1'b0 && valid_o === 1'b1 && ready_i === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got result 0x%0h with nothing expected", result_o);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, "_result"},  result_o,  mon_e.res);
                check({mon_e.name, "_hi"},      hi_o,      mon_e.hi);
                check({mon_e.name, "_zero"},    zero_o,    mon_e.z);
                check({mon_e.name, "_illegal"}, illegal_o, mon_e.ill);
            end
        end
    end

    // Presents a request (at posedge+1) and holds it until accepted; returns 1ns after the accept edge.
    task automatic issue(input string name, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input bit push, input logic [31:0] er,
                         input logic [31:0] eh, input logic ez, input logic ei);
        bit   ok;
        logic r;
        exp_t e;
        valid_i = 1'b1;
        ctrl_i  = c;
        src1_i  = a;
        src2_i  = b;
        ok      = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk_i);
            r = ready_o;
            if (r === 1'b1 && push) begin
                e.name = name; e.res = er; e.hi = eh; e.z = ez; e.ill = ei;
                sb_q.push_back(e);
            end
            @(posedge clk_i);
            #1;
            if (r === 1'b1) ok = 1'b1;
        end
        valid_i = 1'b0;
        ctrl_i  = 4'd5;
        src1_i  = 32'hDEAD_BEEF;
        src2_i  = 32'h1234_5678;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: got no accept, expected accept within 100 cycles", name);
        end
    endtask

    task automatic run_single(input string name, input logic [3:0] c, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] er, input logic ez,
                              input logic ei);
        issue(name, c, a, b, 1'b1, er, 32'h0, ez, ei);
        check({name, "_valid_next_cycle"}, valid_o, 1'b1);
    endtask

    task automatic run_smul(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eh, input logic [31:0] el, input logic ez);
        bit busy_bad;
        issue(name, 4'd13, a, b, 1'b1, el, eh, ez, 1'b0);
        busy_bad = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k != 0) begin
                @(posedge clk_i);
                #1;
            end
            if (ready_o !== 1'b0 || valid_o !== 1'b0) busy_bad = 1'b1;
        end
        check({name, "_busy_ready_low"}, busy_bad, 1'b0);
        @(posedge clk_i);
        #1;
        check({name, "_valid_at_33"}, valid_o, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running after 2 ms");
        $fatal(1);
    end

    initial begin
        bit bp_bad;
        bit rst_bad;
        rst_i   = 1'b1;
        valid_i = 1'b0;
        ctrl_i  = 4'd0;
        src1_i  = 32'h0;
        src2_i  = 32'h0;
        ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_valid",   valid_o,   1'b0);
        check("reset_result",  result_o,  32'h0);
        check("reset_hi",      hi_o,      32'h0);
        check("reset_zero",    zero_o,    1'b0);
        check("reset_illegal", illegal_o, 1'b0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("reset_ready", ready_o, 1'b1);

        // Single-cycle ops, issued back to back.
        run_single("addu_ovf",   4'd4,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b0);
        run_single("subu_zero",  4'd5,  32'h5,         32'h5,         32'h0,         1'b1, 1'b0);
        run_single("sra",        4'd8,  32'h4,         32'h8000_0000, 32'hF800_0000, 1'b0, 1'b0);
        run_single("srav",       4'd9,  32'h24,        32'h7FFF_FFFF, 32'h07FF_FFFF, 1'b0, 1'b0);
        run_single("sll_shamt",  4'd12, 32'd33,        32'h1,         32'h2,         1'b0, 1'b0);
        run_single("lui",        4'd10, 32'h0,         32'h1234,      32'h1234_0000, 1'b0, 1'b0);
        run_single("slt",        4'd6,  32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0);
        run_single("sltu",       4'd11, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0);
        run_single("blez_zero",  4'd7,  32'h0,         32'h7,         32'h0,         1'b1, 1'b0);
        run_single("blez_neg",   4'd7,  32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF, 1'b1, 1'b0);
        run_single("bgtz_zero",  4'd14, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0);
        run_single("bgtz_pos",   4'd14, 32'h5,         32'h0,         32'h5,         1'b1, 1'b0);
        run_single("bgtz_min",   4'd14, 32'h8000_0000, 32'h0,         32'h8000_0000, 1'b0, 1'b0);
        run_single("and",        4'd0,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0);
        run_single("or",         4'd1,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0);
        run_single("lw_add",     4'd2,  32'h3,         32'h4,         32'h7,         1'b0, 1'b0);
        run_single("illegal",    4'd15, 32'h5,         32'h6,         32'h0,         1'b0, 1'b1);
        run_single("sw_add",     4'd3,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0);

        // Multiplies.
        run_smul("smul_neg",  32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_smul("smul_min",  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0);
        run_smul("smul_zero", 32'h0,         32'hFFFF_FFFB, 32'h0,         32'h0,         1'b1);
        run_smul("smul_pos",  32'h0001_0000, 32'h0003_0000, 32'h3,         32'h0,         1'b0);

        // Back-pressure: result must hold while ready_i is low.
        repeat (2) @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        issue("bp_first", 4'd4, 32'd10, 32'd20, 1'b1, 32'd30, 32'h0, 1'b0, 1'b0);
        bp_bad = 1'b0;
        repeat (5) begin
            @(posedge clk_i);
            #1;
            if (valid_o !== 1'b1 || ready_o !== 1'b0 || result_o !== 32'd30 ||
                hi_o !== 32'h0 || zero_o !== 1'b0 || illegal_o !== 1'b0) bp_bad = 1'b1;
        end
        check("bp_hold_stable", bp_bad, 1'b0);
        ready_i = 1'b1;
        issue("bp_next", 4'd4, 32'd1, 32'd2, 1'b1, 32'd3, 32'h0, 1'b0, 1'b0);
        check("bp_next_valid",  valid_o,  1'b1);
        check("bp_next_result", result_o, 32'd3);

        // Reset during a multiply: no result may appear.
        repeat (2) @(posedge clk_i);
        #1;
        issue("smul_abort", 4'd13, 32'd5, 32'd6, 1'b0, 32'd30, 32'h0, 1'b0, 1'b0);
        repeat (10) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("midrst_valid",  valid_o,   1'b0);
        check("midrst_result", result_o,  32'h0);
        check("midrst_hi",     hi_o,      32'h0);
        check("midrst_zero",   zero_o,    1'b0);
        check("midrst_ready",  ready_o,   1'b1);
        rst_i   = 1'b0;
        rst_bad = 1'b0;
        repeat (40) begin
            @(posedge clk_i);
            #1;
            if (valid_o !== 1'b0) rst_bad = 1'b1;
        end
        check("midrst_no_valid", rst_bad, 1'b0);

        run_single("post_rst_addu", 4'd4, 32'h1000, 32'h0234, 32'h1234, 1'b0, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
